// File: rtl/switch_io_axi_slave.sv
// AXI4-Lite register block: synchronised and debounced switches, per-bit change flags, LED drive.
// Define SWITCH_IO_IRQ_EN to build the registered edge-flag interrupt; otherwise irq is tied low.
module switch_io_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_SW             = 8,
    parameter int NUM_LED            = 8,
    parameter int DEBOUNCE_CYCLES    = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [NUM_SW-1:0]               sw_in,
    output logic [NUM_LED-1:0]              led_out,
    output logic                            irq
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_SW    = 2'd0;
    localparam logic [1:0] ADDR_LED   = 2'd1;
    localparam logic [1:0] ADDR_FLAGS = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    logic              r_awready, r_wready, r_bvalid;
    logic              r_arready, r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic [NUM_LED-1:0] r_led;
    logic [1:0]        r_ctrl;
    logic [NUM_SW-1:0] r_sw_meta, r_sw_sync, r_sw_prev;
    logic [NUM_SW-1:0] r_status, r_flags;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_aw_take, w_wr_en, w_rd_en;
    logic [1:0]        w_wr_sel, w_rd_sel;
    logic [DW-1:0]     w_wmask, w_wdata_m, w_led_new, w_rd_mux;
    logic [NUM_SW-1:0] w_w1c, w_set, w_status_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_sw_changed;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
            assign w_wmask[gi*8 +: 8] = {8{S_AXI_WSTRB[gi]}};
        end
    endgenerate

    // Address and data must both be present; the pulse cannot retrigger while a response is pending.
    assign w_aw_take = S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
    assign w_wr_en   = r_awready && S_AXI_AWVALID && r_wready && S_AXI_WVALID;
    assign w_rd_en   = r_arready && S_AXI_ARVALID;
    assign w_wr_sel  = S_AXI_AWADDR[3:2];
    assign w_rd_sel  = S_AXI_ARADDR[3:2];
    assign w_wdata_m = S_AXI_WDATA & w_wmask;
    assign w_led_new = (DW'(r_led) & ~w_wmask) | w_wdata_m;
    assign w_w1c     = (w_wr_en && w_wr_sel == ADDR_FLAGS) ? w_wdata_m[NUM_SW-1:0] : '0;

    assign w_sw_changed  = (r_sw_sync != r_sw_prev);
    assign w_cnt_next    = w_sw_changed ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
    assign w_status_next = (r_ctrl[1] || w_cnt_next == CNT_MAX) ? r_sw_sync : r_status;
    assign w_set         = w_status_next ^ r_status;

    always_comb begin
        w_rd_mux = '0;
        case (w_rd_sel)
            ADDR_SW:    w_rd_mux = DW'(r_status);
            ADDR_LED:   w_rd_mux = DW'(r_led);
            ADDR_FLAGS: w_rd_mux = DW'(r_flags);
            ADDR_CTRL:  w_rd_mux = DW'(r_ctrl);
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_led     <= '0;
            r_ctrl    <= '0;
        end else begin
            r_awready <= w_aw_take;
            r_wready  <= w_aw_take;
            if (w_wr_en)
                r_bvalid <= 1'b1;
            else if (S_AXI_BREADY)
                r_bvalid <= 1'b0;
            if (w_wr_en && w_wr_sel == ADDR_LED)
                r_led <= w_led_new[NUM_LED-1:0];
            if (w_wr_en && w_wr_sel == ADDR_CTRL && S_AXI_WSTRB[0])
                r_ctrl <= S_AXI_WDATA[1:0];
        end
    end

    // Read data is captured before same-edge writes land, so a colliding read sees the old value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= S_AXI_ARVALID && !r_rvalid && !r_arready;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_sw_prev <= '0;
            r_cnt     <= '0;
            r_status  <= '0;
            r_flags   <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            r_sw_prev <= r_sw_sync;
            r_cnt     <= w_cnt_next;
            r_status  <= w_status_next;
            // A new change event beats a simultaneous write-one-to-clear.
            r_flags   <= (r_flags & ~w_w1c) | w_set;
        end
    end

    logic w_unused;
`ifdef SWITCH_IO_IRQ_EN
    logic r_irq;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            r_irq <= 1'b0;
        else
            r_irq <= r_ctrl[0] && (|r_flags);
    end
    assign irq      = r_irq;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, w_wdata_m, w_led_new};
`else
    assign irq      = 1'b0;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, w_wdata_m, w_led_new,
                        r_ctrl[0]};
`endif

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign led_out       = r_led;

endmodule

// File: tb/tb_switch_io_axi_slave.sv
// Directed bench for switch_io_axi_slave: read results are scoreboarded at issue and checked on RVALID.
// Honours SWITCH_IO_IRQ_EN for the expected irq behaviour.
module tb_switch_io_axi_slave;
`ifdef SWITCH_IO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [7:0]  sw_in, led_out;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    switch_io_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .NUM_SW(8),
        .NUM_LED(8),
        .DEBOUNCE_CYCLES(16)
    ) u_dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),  .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid),  .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),  .S_AXI_RREADY(rready),
        .sw_in(sw_in),          .led_out(led_out),      .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_awready();
        int n = 0;
        while (!awready && n < 20) begin
            tick(1);
            n++;
        end
        check("wr_accept", {31'd0, awready && wready}, 32'd1);
    endtask

    task automatic wait_arready();
        int n = 0;
        while (!arready && n < 20) begin
            tick(1);
            n++;
        end
        check("rd_accept", {31'd0, arready}, 32'd1);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!rvalid && n < 20) begin
            tick(1);
            n++;
        end
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
    endtask

    task automatic pop_compare();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.tag, rdata, e.data);
            check({e.tag, "_rresp"}, {30'd0, rresp}, 32'd0);
            $display("read  %-14s data=0x%08h exp=0x%08h", e.tag, rdata, e.data);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_awready();
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 20) begin
            tick(1);
            n++;
        end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        $display("write addr=0x%h data=0x%08h strb=0x%h", addr, data, strb);
    endtask

    // Read issued just after edge X returns register state as of edge X+1.
    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        sb.push_back('{tag, exp});
        araddr = addr; arvalid = 1'b1;
        wait_arready();
        tick(1);
        arvalid = 1'b0;
        wait_rvalid();
        pop_compare();
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; sw_in = '0;
        #500;
        check("rst_handshake", {26'd0, awready, wready, bvalid, arready, rvalid, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_led", {24'd0, led_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);

        axi_read(4'h0, 32'h0, "rst_sw");
        axi_read(4'h4, 32'h0, "rst_led_reg");
        axi_read(4'h8, 32'h0, "rst_flags");
        axi_read(4'hC, 32'h0, "rst_ctrl");

        // LED register and byte strobes
        axi_write(4'h4, 32'h0000_00A5, 4'hF);
        axi_read(4'h4, 32'h0000_00A5, "led_a5");
        check("led_out_a5", {24'd0, led_out}, 32'hA5);
        axi_write(4'h4, 32'hFFFF_FF00, 4'h1);
        axi_read(4'h4, 32'h0, "led_strb1");
        axi_write(4'h4, 32'hFFFF_FFFF, 4'h2);
        axi_read(4'h4, 32'h0, "led_above");
        check("led_out_0", {24'd0, led_out}, 32'h0);
        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
        axi_read(4'h0, 32'h0, "sw_ro");
        axi_write(4'hC, 32'hFFFF_FFFC, 4'hF);
        axi_read(4'hC, 32'h0, "ctrl_unused");

        // Write backpressure: a second write stays pending while B is unacknowledged
        awaddr = 4'h4; wdata = 32'h5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_awready();
        tick(1);
        wdata = 32'h33;
        for (int i = 0; i < 10; i++) begin
            check("bp_b_hold", {27'd0, bvalid, awready, wready, bresp}, 32'b10000);
            check("bp_led_first", {24'd0, led_out}, 32'h5A);
            tick(1);
        end
        bready = 1'b1;
        tick(1);
        check("bp_b_release", {30'd0, bvalid, awready}, 32'd0);
        wait_awready();
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_b_second", {31'd0, bvalid}, 32'd1);
        tick(1);
        bready = 1'b0;
        check("bp_led_second", {24'd0, led_out}, 32'h33);
        $display("write backpressure pair led=0x%02h", led_out);

        // Read backpressure: a second read stays pending while R is unacknowledged
        araddr = 4'h4; arvalid = 1'b1;
        sb.push_back('{"bp_rd_first", 32'h33});
        wait_arready();
        tick(1);
        araddr = 4'h8;
        sb.push_back('{"bp_rd_second", 32'h0});
        for (int i = 0; i < 10; i++) begin
            check("bp_r_hold", {30'd0, rvalid, arready}, 32'b10);
            check("bp_rdata_hold", rdata, sb[0].data);
            tick(1);
        end
        rready = 1'b1;
        pop_compare();
        tick(1);
        wait_arready();
        tick(1);
        arvalid = 1'b0;
        wait_rvalid();
        pop_compare();
        tick(1);
        rready = 1'b0;

        // Short glitch never reaches SW_STATUS
        sw_in = 8'h3C;
        tick(5);
        sw_in = 8'h00;
        tick(30);
        axi_read(4'h0, 32'h0, "glitch_sw");
        axi_read(4'h8, 32'h0, "glitch_flags");

        // Debounce boundary: new value appears exactly 18 edges after the change
        sw_in = 8'h3C;
        tick(16);
        axi_read(4'h0, 32'h0, "db_early");
        tick(20);
        axi_read(4'h0, 32'h3C, "db_final");
        axi_read(4'h8, 32'h3C, "db_flags");
        sw_in = 8'h00;
        tick(17);
        axi_read(4'h0, 32'h0, "db_late");
        axi_read(4'h8, 32'h3C, "db_flags_keep");
        sw_in = 8'h3C;
        tick(25);
        axi_read(4'h0, 32'h3C, "db_back");

        // Bypass: SW_STATUS follows 3 edges after the change
        axi_write(4'hC, 32'h2, 4'hF);
        sw_in = 8'h38;
        tick(1);
        axi_read(4'h0, 32'h3C, "byp_early");
        tick(10);
        sw_in = 8'h3C;
        tick(2);
        axi_read(4'h0, 32'h3C, "byp_on_time");

        // W1C of bit2 lands on the same edge bit2 changes again: set wins
        sw_in = 8'h38;
        tick(1);
        axi_write(4'h8, 32'h04, 4'hF);
        axi_read(4'h8, 32'h3C, "w1c_race");
        axi_write(4'h8, 32'h3C, 4'hF);
        axi_read(4'h8, 32'h0, "w1c_clear");

        // Interrupt: enable, toggle sw_in[0] through the debouncer, then clear the flag
        axi_write(4'hC, 32'h1, 4'hF);
        check("irq_idle", {31'd0, irq}, 32'd0);
        sw_in = 8'h39;
        tick(18);
        check("irq_before", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_assert", {31'd0, irq}, {31'd0, IRQ_ON});
        axi_read(4'h8, 32'h01, "irq_flags");
        axi_read(4'h0, 32'h39, "irq_sw");
        axi_write(4'h8, 32'h01, 4'hF);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        axi_read(4'h8, 32'h0, "irq_flags_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
